// File: rtl/inst_encoder_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : inst_encoder_writer                                           |
// | Purpose  : Packs decoded MIPS R/I/J instruction fields into 32-bit words  |
// |            and writes them to consecutive instruction-memory locations,   |
// |            starting at word address 0, for in-system program loading.     |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, reset       : rising-edge clock, asynchronous active-high reset    |
// |   start            : one-cycle pulse opening a load session              |
// |   in_valid/in_ready: field-bundle handshake                              |
// |   fmt              : 00=R, 01=I, 10=J, 11=illegal                        |
// |   opcode..address  : instruction fields                                  |
// |   last             : final bundle of the session                         |
// |   mem_we/addr/wdata: one-word-per-cycle memory write port (registered)   |
// |   count            : words written this session                          |
// |   busy / done      : FSM in LOAD / FSM in DONE                           |
// |   overflow         : sticky, memory filled before last was accepted      |
// |   fmt_err          : sticky, an illegal-format bundle was accepted       |
// +--------------------------------------------------------------------------+
module inst_encoder_writer #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       immediate,
  input  logic [25:0]       address,
  input  logic              last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              fmt_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] FULL_C = (ADDR_W+1)'(DEPTH);

  state_t            state;
  // The write pointer and the session word count advance together on every
  // legal write and are cleared together on start, so one register serves both.
  logic [ADDR_W:0]   ptr;
  logic              last_acc;
  logic              accept;
  logic [31:0]       word;

  // ptr never exceeds DEPTH, so "ptr < DEPTH" reduces to an inequality test.
  assign in_ready = (state == LOAD) && (ptr != FULL_C) && !last_acc;
  assign accept   = in_valid && in_ready;
  assign count    = ptr;
  assign busy     = (state == LOAD);
  assign done     = (state == DONE);

  always_comb begin
    word = 32'h0;
    case (fmt)
      2'b00:   word = {6'h00, rs, rt, rd, shamt, funct};
      2'b01:   word = {opcode, rs, rt, immediate};
      2'b10:   word = {opcode, address};
      default: word = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      last_acc  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      overflow  <= 1'b0;
      fmt_err   <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse per accepted legal bundle.
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= LOAD;
            ptr      <= '0;
            last_acc <= 1'b0;
            overflow <= 1'b0;
            fmt_err  <= 1'b0;
          end
        end
        LOAD: begin
          // Session end is taken one edge after the final write so that the
          // write cycle itself is still reported as busy.
          if (last_acc) begin
            state <= DONE;
          end else if (ptr == FULL_C) begin
            state    <= DONE;
            overflow <= 1'b1;
          end else if (accept) begin
            last_acc <= last;
            if (fmt == 2'b11) begin
              fmt_err <= 1'b1;
            end else begin
              mem_we    <= 1'b1;
              mem_addr  <= ptr[ADDR_W-1:0];
              mem_wdata <= word;
              ptr       <= ptr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
